// File: rtl/avalon_pkg.sv
// Shared types for the Avalon-MM burst memory responder: burst FSM states and
// the byte-laned 32-bit word used on the RAM boundary.
package avalon_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } burst_state_e;

  typedef logic [3:0][7:0] word_t;

endpackage

// File: rtl/be_ram_1r1w.sv
// 2^ADD_WIDTH x 32 RAM, one byte-lane write port and one registered read port.
// Optional preload with word i = i*i when AVALON_BURST_RAM_INIT_EN is defined.
module be_ram_1r1w
  import avalon_pkg::*;
#(
  parameter int ADD_WIDTH = 13
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [3:0]           be,
  input  logic [ADD_WIDTH-1:0] waddr,
  input  word_t                wdata,
  input  logic                 re,
  input  logic [ADD_WIDTH-1:0] raddr,
  output word_t                rdata
);

  localparam int DEPTH = 2 ** ADD_WIDTH;

  word_t mem [DEPTH];
  word_t rdata_q;

`ifdef AVALON_BURST_RAM_INIT_EN
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = word_t'(i * i);
    end
  end
`endif

  // No reset on the array or read register so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[waddr][b] <= wdata[b];
        end
      end
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/avalon_burst_ram.sv
// Avalon-MM burst-capable memory responder with fixed read latency and byte
// enables. Build option: AVALON_BURST_RAM_INIT_EN preloads the RAM (see be_ram_1r1w).
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | accepting commands; issues beat 0 of a read or write
//   RD_BURST | issuing remaining read beats, one per cycle; waitRequest high
//   WR_BURST | writing remaining beats on cycles with s0_write high
module avalon_burst_ram
  import avalon_pkg::*;
#(
  parameter int SIZE         = 32,
  parameter int READ_LATENCY = 1,
  parameter int BURST_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rest,
  input  logic [31:0]            s0_address,
  input  logic [3:0]             s0_byteEnable,
  input  logic                   s0_read,
  input  logic                   s0_write,
  input  logic [31:0]            s0_writeData,
  input  logic                   s0_beginBurstTransfer,
  input  logic [BURST_WIDTH-1:0] s0_burstCount,
  output logic [31:0]            s0_readData,
  output logic                   s0_waitRequest,
  output logic                   s0_readDataValid
);

  localparam int ADD_WIDTH = $clog2(SIZE) + 10 - 2;
  localparam logic [ADD_WIDTH-1:0]   ADDR_ONE = 1;
  localparam logic [BURST_WIDTH-1:0] CNT_ONE  = 1;

  burst_state_e state_q, state_d;
  logic [ADD_WIDTH-1:0]   addr_q, addr_d;
  logic [BURST_WIDTH-1:0] rem_q, rem_d;
  logic [READ_LATENCY-1:0] valid_q, valid_d;

  logic [ADD_WIDTH-1:0]   cmd_addr;
  logic [BURST_WIDTH-1:0] cmd_len;
  logic                   rd_issue;
  logic [ADD_WIDTH-1:0]   rd_addr;
  logic                   wr_en;
  logic [ADD_WIDTH-1:0]   wr_addr;
  word_t                  ram_rdata;
  word_t                  out_data;

  // Only the word-index bits of the address are decoded.
  logic unused_ok;
  assign unused_ok = ^{s0_beginBurstTransfer, s0_address};

  assign cmd_addr = s0_address[ADD_WIDTH+1:2];
  assign cmd_len  = (s0_burstCount == '0) ? CNT_ONE : s0_burstCount;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    rd_issue = 1'b0;
    rd_addr  = addr_q;
    wr_en    = 1'b0;
    wr_addr  = addr_q;
    case (state_q)
      IDLE: begin
        // Write wins when both commands are presented together.
        if (s0_write) begin
          wr_en   = 1'b1;
          wr_addr = cmd_addr;
          addr_d  = cmd_addr + ADDR_ONE;
          rem_d   = cmd_len - CNT_ONE;
          if (cmd_len > CNT_ONE) state_d = WR_BURST;
        end else if (s0_read) begin
          rd_issue = 1'b1;
          rd_addr  = cmd_addr;
          addr_d   = cmd_addr + ADDR_ONE;
          rem_d    = cmd_len - CNT_ONE;
          if (cmd_len > CNT_ONE) state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        rd_issue = 1'b1;
        addr_d   = addr_q + ADDR_ONE;
        rem_d    = rem_q - CNT_ONE;
        if (rem_q == CNT_ONE) state_d = IDLE;
      end
      WR_BURST: begin
        if (s0_write) begin
          wr_en  = 1'b1;
          addr_d = addr_q + ADDR_ONE;
          rem_d  = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d    = '0;
    valid_d[0] = rd_issue;
    for (int i = 1; i < READ_LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rest) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
    end
  end

  // Write is suppressed on a reset edge so an aborted burst stops immediately.
  be_ram_1r1w #(
    .ADD_WIDTH(ADD_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en & rest),
    .be   (s0_byteEnable),
    .waddr(wr_addr),
    .wdata(s0_writeData),
    .re   (rd_issue),
    .raddr(rd_addr),
    .rdata(ram_rdata)
  );

  // The RAM read register is the first latency stage; extra stages follow it.
  generate
    if (READ_LATENCY > 1) begin : g_dpipe
      word_t data_q [READ_LATENCY-1];
      word_t data_d [READ_LATENCY-1];

      always_comb begin
        data_d[0] = ram_rdata;
        for (int i = 1; i < READ_LATENCY - 1; i++) begin
          data_d[i] = data_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        data_q <= data_d;
      end

      assign out_data = data_q[READ_LATENCY-2];
    end else begin : g_dnone
      assign out_data = ram_rdata;
    end
  endgenerate

  assign s0_readDataValid = valid_q[READ_LATENCY-1];
  assign s0_readData      = valid_q[READ_LATENCY-1] ? out_data : '0;
  assign s0_waitRequest   = (state_q == RD_BURST);

endmodule

// File: tb/tb_avalon_burst_ram.sv
// Scoreboard bench for avalon_burst_ram (READ_LATENCY=3): expected read beats
// are queued with their due cycle at issue and matched at the negedge monitor.
module tb_avalon_burst_ram;

  localparam int SIZE         = 32;
  localparam int READ_LATENCY = 3;
  localparam int BURST_WIDTH  = 8;
  localparam int ADD_WIDTH    = 13;
  localparam int DEPTH        = 2 ** ADD_WIDTH;
  localparam int MASK         = DEPTH - 1;

  logic                   clk = 1'b0;
  logic                   rest;
  logic [31:0]            s0_address;
  logic [3:0]             s0_byteEnable;
  logic                   s0_read;
  logic                   s0_write;
  logic [31:0]            s0_writeData;
  logic                   s0_beginBurstTransfer;
  logic [BURST_WIDTH-1:0] s0_burstCount;
  logic [31:0]            s0_readData;
  logic                   s0_waitRequest;
  logic                   s0_readDataValid;

  avalon_burst_ram #(
    .SIZE(SIZE),
    .READ_LATENCY(READ_LATENCY),
    .BURST_WIDTH(BURST_WIDTH)
  ) dut (
    .clk                  (clk),
    .rest                 (rest),
    .s0_address           (s0_address),
    .s0_byteEnable        (s0_byteEnable),
    .s0_read              (s0_read),
    .s0_write             (s0_write),
    .s0_writeData         (s0_writeData),
    .s0_beginBurstTransfer(s0_beginBurstTransfer),
    .s0_burstCount        (s0_burstCount),
    .s0_readData          (s0_readData),
    .s0_waitRequest       (s0_waitRequest),
    .s0_readDataValid     (s0_readDataValid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [DEPTH];
  logic [31:0] burst_buf [16];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Outputs change only at posedge; compare valid timing and data at negedge.
  always @(negedge clk) begin
    logic due;
    due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    if (s0_readDataValid === 1'b1 || due) begin
      check_eq("rd_valid", {31'd0, s0_readDataValid}, {31'd0, due});
      if (due) begin
        if (s0_readDataValid === 1'b1) check_eq("rd_data", s0_readData, exp_q[0].data);
        void'(exp_q.pop_front());
      end
    end
  end

  function automatic void model_write(input int w, input logic [3:0] be, input logic [31:0] d);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) model[w & MASK][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  // All tasks start and end at a negedge with commands deasserted.
  task automatic write_single(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] d);
    check_eq("wr_wait", {31'd0, s0_waitRequest}, 32'd0);
    s0_address = addr; s0_byteEnable = be; s0_writeData = d;
    s0_write = 1'b1; s0_burstCount = 8'd1; s0_beginBurstTransfer = 1'b1;
    model_write(int'(addr[ADD_WIDTH+1:2]), be, d);
    @(posedge clk);
    @(negedge clk);
    s0_write = 1'b0; s0_beginBurstTransfer = 1'b0;
  endtask

  task automatic write_burst(input logic [31:0] addr, input int n, input int gap_after, input int gap_len);
    int w0;
    w0 = int'(addr[ADD_WIDTH+1:2]);
    for (int k = 0; k < n; k++) begin
      check_eq("wr_burst_wait", {31'd0, s0_waitRequest}, 32'd0);
      s0_address = (k == 0) ? addr : 32'hDEAD_BEE0;
      s0_byteEnable = 4'hf; s0_writeData = burst_buf[k]; s0_write = 1'b1;
      s0_burstCount = BURST_WIDTH'(n); s0_beginBurstTransfer = (k == 0);
      model_write(w0 + k, 4'hf, burst_buf[k]);
      @(posedge clk);
      @(negedge clk);
      s0_write = 1'b0; s0_beginBurstTransfer = 1'b0;
      if (k == gap_after) begin
        s0_read = 1'b1;
        s0_address = addr + 32'h40;
        repeat (gap_len) @(negedge clk);
        s0_read = 1'b0;
      end
    end
  endtask

  task automatic read_burst(input logic [31:0] addr, input int n);
    int len, w0, t, w;
    len = (n == 0) ? 1 : n;
    w0  = int'(addr[ADD_WIDTH+1:2]);
    check_eq("rd_accept_wait", {31'd0, s0_waitRequest}, 32'd0);
    s0_address = addr; s0_read = 1'b1; s0_burstCount = BURST_WIDTH'(n);
    s0_beginBurstTransfer = 1'b1;
    t = cyc + 1;
    for (int k = 0; k < len; k++) begin
      exp_q.push_back('{data: model[(w0 + k) & MASK], cyc: t + READ_LATENCY - 1 + k});
    end
    @(posedge clk);
    @(negedge clk);
    s0_read = 1'b0; s0_beginBurstTransfer = 1'b0;
    w = 0;
    while (s0_waitRequest === 1'b1 && w < len + 4) begin
      w++;
      @(negedge clk);
    end
    check_eq("rd_wait_cycles", w, len - 1);
  endtask

  // Reset asserted so that the reset edge is the one that would issue beat rst_beat.
  task automatic read_burst_abort(input logic [31:0] addr, input int n, input int rst_beat);
    int w0, t;
    w0 = int'(addr[ADD_WIDTH+1:2]);
    s0_address = addr; s0_read = 1'b1; s0_burstCount = BURST_WIDTH'(n);
    t = cyc + 1;
    for (int k = 0; k < n; k++) begin
      if (t + READ_LATENCY - 1 + k < t + rst_beat)
        exp_q.push_back('{data: model[(w0 + k) & MASK], cyc: t + READ_LATENCY - 1 + k});
    end
    @(posedge clk);
    @(negedge clk);
    s0_read = 1'b0;
    for (int i = 0; i < 16 && cyc < t + rst_beat - 1; i++) @(negedge clk);
    rest = 1'b0;
    @(negedge clk);
    rest = 1'b1;
    check_eq("abort_wait", {31'd0, s0_waitRequest}, 32'd0);
    check_eq("abort_valid", {31'd0, s0_readDataValid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rest = 1'b0;
    s0_address = '0; s0_byteEnable = '0; s0_read = 1'b0; s0_write = 1'b0;
    s0_writeData = '0; s0_beginBurstTransfer = 1'b0; s0_burstCount = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_valid", {31'd0, s0_readDataValid}, 32'd0);
    check_eq("reset_data", s0_readData, 32'd0);
    check_eq("reset_wait", {31'd0, s0_waitRequest}, 32'd0);
    rest = 1'b1;
    @(negedge clk);

    // Single write then back-to-back read of the same word.
    write_single(32'h0000_0004, 4'hf, 32'h1234_5678);
    read_burst(32'h0000_0004, 1);

    // Partial write over a known word.
    write_single(32'h0000_0010, 4'hf, 32'h0000_0010);
    write_single(32'h0000_0010, 4'hc, 32'hAABB_CCDD);
    read_burst(32'h0000_0010, 1);
    check_eq("partial_model", model[4], 32'hAABB_0010);

    // Words 0x40..0x47 = i*i, then an 8-beat read burst from 0x100.
    for (int i = 0; i < 8; i++) burst_buf[i] = (32'h40 + i) * (32'h40 + i);
    write_burst(32'h0000_0100, 8, -1, 0);
    read_burst(32'h0000_0100, 8);

    // Write burst with a 2-cycle gap after beat 1 (read held high in the gap).
    write_single(32'h0000_0210, 4'hf, 32'h5EA5_EA5E);
    for (int i = 0; i < 4; i++) burst_buf[i] = 32'hC0DE_0000 + 32'(i);
    write_burst(32'h0000_0200, 4, 1, 2);
    read_burst(32'h0000_0200, 5);

    // Simultaneous read and write: only the write is serviced.
    s0_address = 32'h0000_0300; s0_byteEnable = 4'hf; s0_writeData = 32'hFACE_B00C;
    s0_write = 1'b1; s0_read = 1'b1; s0_burstCount = 8'd1;
    model_write(32'h300 >> 2, 4'hf, 32'hFACE_B00C);
    @(posedge clk);
    @(negedge clk);
    s0_write = 1'b0; s0_read = 1'b0;
    read_burst(32'h0000_0300, 1);

    // Burst count 0 behaves as a single beat.
    read_burst(32'h0000_0004, 0);

    // Wrap from the top word to word 0; upper address bits are ignored.
    write_single(32'h0000_7FFC, 4'hf, 32'h7070_FFFF);
    write_single(32'h0000_0000, 4'hf, 32'h0000_AAAA);
    write_single(32'h0000_0004, 4'hf, 32'h1111_BBBB);
    write_single(32'h0000_0008, 4'hf, 32'h2222_CCCC);
    read_burst(32'hF000_7FFC, 4);

    // Reset on the edge that would issue beat 3 of an 8-beat read.
    read_burst_abort(32'h0000_0100, 8, 3);
    repeat (READ_LATENCY + 2) @(negedge clk);
    read_burst(32'h0000_0104, 1);
    read_burst(32'h0000_0200, 2);

    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
    repeat (READ_LATENCY + 2) @(negedge clk);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
